// File: rtl/ex_mem.sv
// rtl/ex_mem.sv - EX/MEM pipeline register with stall/flush handling and multi-cycle EX feedback
module ex_mem #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int ALUOP_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic [ADDR_W-1:0]   ex_wd,
    input  logic                ex_wreg,
    input  logic [DATA_W-1:0]   ex_wdata,
    input  logic                ex_whilo,
    input  logic [DATA_W-1:0]   ex_hi,
    input  logic [DATA_W-1:0]   ex_lo,
    input  logic [ALUOP_W-1:0]  ex_aluop,
    input  logic [DATA_W-1:0]   ex_mem_addr,
    input  logic [DATA_W-1:0]   ex_reg2,
    input  logic [2*DATA_W-1:0] hilo_i,
    input  logic [1:0]          cnt_i,
    output logic [ADDR_W-1:0]   mem_wd,
    output logic                mem_wreg,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic                mem_whilo,
    output logic [DATA_W-1:0]   mem_hi,
    output logic [DATA_W-1:0]   mem_lo,
    output logic [ALUOP_W-1:0]  mem_aluop,
    output logic [DATA_W-1:0]   mem_mem_addr,
    output logic [DATA_W-1:0]   mem_reg2,
    output logic [2*DATA_W-1:0] hilo_o,
    output logic [1:0]          cnt_o
);

    logic ex_stalled;
    logic mem_stalled;
    logic bubble;
    logic advance;

    assign ex_stalled  = stall[3];
    assign mem_stalled = stall[4];
    // EX held while MEM moves on: MEM must see a no-op, not a repeat of the instruction.
    assign bubble      = ex_stalled && !mem_stalled;
    // An illegal EX-advance/MEM-stall vector still advances, keeping behaviour deterministic.
    assign advance     = !ex_stalled;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            hilo_o       <= '0;
            cnt_o        <= 2'd0;
        end else if (bubble) begin
            mem_wd       <= '0;
            mem_wreg     <= 1'b0;
            mem_wdata    <= '0;
            mem_whilo    <= 1'b0;
            mem_hi       <= '0;
            mem_lo       <= '0;
            mem_aluop    <= '0;
            mem_mem_addr <= '0;
            mem_reg2     <= '0;
            hilo_o       <= hilo_i;
            cnt_o        <= cnt_i;
        end else if (advance) begin
            mem_wd       <= ex_wd;
            mem_wreg     <= ex_wreg;
            mem_wdata    <= ex_wdata;
            mem_whilo    <= ex_whilo;
            mem_hi       <= ex_hi;
            mem_lo       <= ex_lo;
            mem_aluop    <= ex_aluop;
            mem_mem_addr <= ex_mem_addr;
            mem_reg2     <= ex_reg2;
            hilo_o       <= '0;
            cnt_o        <= 2'd0;
        end
        // Both EX and MEM stalled: every register holds, including the accumulate state.
    end

endmodule

// File: tb/tb_ex_mem.sv
// tb/tb_ex_mem.sv - self-checking bench for ex_mem using directed vector table and hand sequences
module tb_ex_mem;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic [5:0]  stall;
    logic [4:0]  ex_wd;
    logic        ex_wreg, ex_whilo;
    logic [31:0] ex_wdata, ex_hi, ex_lo, ex_mem_addr, ex_reg2;
    logic [7:0]  ex_aluop;
    logic [63:0] hilo_i;
    logic [1:0]  cnt_i;
    logic [4:0]  mem_wd;
    logic        mem_wreg, mem_whilo;
    logic [31:0] mem_wdata, mem_hi, mem_lo, mem_mem_addr, mem_reg2;
    logic [7:0]  mem_aluop;
    logic [63:0] hilo_o;
    logic [1:0]  cnt_o;

    int n_vec = 0;
    int n_bad = 0;

    ex_mem dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
        .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
        .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
        .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
        .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
        .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
    );

    always #5 clk = ~clk;

    // Each instruction tag expands into a distinct payload; tag 0 stands for an all-zero bubble.
    typedef struct {
        logic [4:0]  wd;
        logic [31:0] wdata, hi, lo, addr, reg2;
        logic [7:0]  aluop;
    } fields_t;

    function automatic fields_t expand(input logic [7:0] id);
        fields_t f;
        if (id == 8'd0) begin
            f.wd = '0; f.wdata = '0; f.hi = '0; f.lo = '0; f.addr = '0; f.reg2 = '0; f.aluop = '0;
        end else begin
            f.wd    = id[4:0];
            f.wdata = {4{id}};
            f.hi    = {4{id ^ 8'h5A}};
            f.lo    = {4{~id}};
            f.addr  = {4{id ^ 8'hC3}};
            f.reg2  = {4{id + 8'h40}};
            f.aluop = id ^ 8'h3C;
        end
        return f;
    endfunction

    typedef struct {
        logic        rst, flush;
        logic [5:0]  stall;
        logic [7:0]  id;
        logic        wreg, whilo;
        logic [63:0] hilo_i;
        logic [1:0]  cnt_i;
        logic [7:0]  e_id;
        logic        e_wreg, e_whilo;
        logic [63:0] e_hilo;
        logic [1:0]  e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic [5:0] s, input logic [7:0] id,
                                input logic wr, input logic wh, input logic [63:0] hi_in, input logic [1:0] c_in,
                                input logic [7:0] eid, input logic ewr, input logic ewh,
                                input logic [63:0] ehilo, input logic [1:0] ecnt);
        vec_t v;
        v.rst = r; v.flush = f; v.stall = s; v.id = id; v.wreg = wr; v.whilo = wh;
        v.hilo_i = hi_in; v.cnt_i = c_in;
        v.e_id = eid; v.e_wreg = ewr; v.e_whilo = ewh; v.e_hilo = ehilo; v.e_cnt = ecnt;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] id, input logic wr, input logic wh);
        fields_t f;
        f = expand(id);
        ex_wd = f.wd; ex_wdata = f.wdata; ex_hi = f.hi; ex_lo = f.lo;
        ex_mem_addr = f.addr; ex_reg2 = f.reg2; ex_aluop = f.aluop;
        ex_wreg = wr; ex_whilo = wh;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] eid, input logic ewr, input logic ewh,
                           input logic [63:0] ehilo, input logic [1:0] ecnt);
        fields_t f;
        f = expand(eid);
        chk({tag, ".wd"},    64'(mem_wd),       64'(f.wd));
        chk({tag, ".wreg"},  64'(mem_wreg),     64'(ewr));
        chk({tag, ".wdata"}, 64'(mem_wdata),    64'(f.wdata));
        chk({tag, ".whilo"}, 64'(mem_whilo),    64'(ewh));
        chk({tag, ".hi"},    64'(mem_hi),       64'(f.hi));
        chk({tag, ".lo"},    64'(mem_lo),       64'(f.lo));
        chk({tag, ".aluop"}, 64'(mem_aluop),    64'(f.aluop));
        chk({tag, ".addr"},  64'(mem_mem_addr), 64'(f.addr));
        chk({tag, ".reg2"},  64'(mem_reg2),     64'(f.reg2));
        chk({tag, ".hilo"},  hilo_o,            ehilo);
        chk({tag, ".cnt"},   64'(cnt_o),        64'(ecnt));
    endtask

    localparam logic [5:0]  S_RUN  = 6'b000000;
    localparam logic [5:0]  S_EX   = 6'b001111;
    localparam logic [5:0]  S_HOLD = 6'b011111;
    localparam logic [5:0]  S_ILL  = 6'b010000;
    localparam logic [63:0] P1 = 64'h0000_0001_FFFF_FFFE;
    localparam logic [63:0] P2 = 64'hDEAD_BEEF_0123_4567;
    localparam logic [63:0] P3 = 64'h8000_0000_0000_0001;
    localparam logic [63:0] P4 = 64'h1111_2222_3333_4444;

    vec_t vt[20];

    initial begin
        vt[0]  = mk(1, 0, S_RUN,  8'd9,  1, 1, P2, 2'd1,  8'd0,  0, 0, 64'd0, 2'd0);
        vt[1]  = mk(1, 0, S_EX,   8'd9,  1, 1, P2, 2'd1,  8'd0,  0, 0, 64'd0, 2'd0);
        vt[2]  = mk(0, 0, S_RUN,  8'd1,  1, 0, P2, 2'd1,  8'd1,  1, 0, 64'd0, 2'd0);
        vt[3]  = mk(0, 0, S_RUN,  8'd2,  0, 1, P3, 2'd0,  8'd2,  0, 1, 64'd0, 2'd0);
        vt[4]  = mk(0, 0, S_RUN,  8'd3,  1, 1, 64'd0, 2'd0, 8'd3, 1, 1, 64'd0, 2'd0);
        vt[5]  = mk(0, 0, S_RUN,  8'd4,  1, 0, 64'd0, 2'd0, 8'd4, 1, 0, 64'd0, 2'd0);
        vt[6]  = mk(0, 0, S_EX,   8'd5,  1, 1, P1, 2'd1,  8'd0,  0, 0, P1,    2'd1);
        vt[7]  = mk(0, 0, S_HOLD, 8'd6,  1, 1, P2, 2'd2,  8'd0,  0, 0, P1,    2'd1);
        vt[8]  = mk(0, 0, S_RUN,  8'd5,  1, 1, P3, 2'd1,  8'd5,  1, 1, 64'd0, 2'd0);
        vt[9]  = mk(0, 0, S_HOLD, 8'd7,  0, 0, P4, 2'd1,  8'd5,  1, 1, 64'd0, 2'd0);
        vt[10] = mk(0, 0, S_EX,   8'd7,  1, 0, P2, 2'd1,  8'd0,  0, 0, P2,    2'd1);
        vt[11] = mk(0, 1, S_EX,   8'd8,  1, 1, P3, 2'd2,  8'd0,  0, 0, 64'd0, 2'd0);
        vt[12] = mk(0, 0, S_EX,   8'd8,  1, 1, P4, 2'd1,  8'd0,  0, 0, P4,    2'd1);
        vt[13] = mk(0, 1, S_HOLD, 8'd8,  1, 1, P2, 2'd1,  8'd0,  0, 0, 64'd0, 2'd0);
        vt[14] = mk(0, 0, S_RUN,  8'd10, 1, 1, P2, 2'd1,  8'd10, 1, 1, 64'd0, 2'd0);
        vt[15] = mk(0, 1, S_RUN,  8'd11, 1, 1, P2, 2'd1,  8'd0,  0, 0, 64'd0, 2'd0);
        vt[16] = mk(0, 0, S_ILL,  8'd12, 1, 0, P3, 2'd1,  8'd12, 1, 0, 64'd0, 2'd0);
        vt[17] = mk(0, 0, S_EX,   8'd12, 1, 0, P3, 2'd1,  8'd0,  0, 0, P3,    2'd1);
        vt[18] = mk(1, 0, S_EX,   8'd12, 1, 0, P4, 2'd1,  8'd0,  0, 0, 64'd0, 2'd0);
        vt[19] = mk(0, 0, S_RUN,  8'd13, 0, 1, P4, 2'd1,  8'd13, 0, 1, 64'd0, 2'd0);

        rst = 1'b0; flush = 1'b0; stall = S_RUN; hilo_i = '0; cnt_i = '0;
        drive(8'd0, 1'b0, 1'b0);
        @(posedge clk); #1;

        for (int i = 0; i < 20; i++) begin
            rst = vt[i].rst; flush = vt[i].flush; stall = vt[i].stall;
            hilo_i = vt[i].hilo_i; cnt_i = vt[i].cnt_i;
            drive(vt[i].id, vt[i].wreg, vt[i].whilo);
            @(posedge clk); #1;
            chk_all($sformatf("v%0d", i), vt[i].e_id, vt[i].e_wreg, vt[i].e_whilo, vt[i].e_hilo, vt[i].e_cnt);
        end

        // Literal pass-through; the new inputs must not reach mem_* before the edge.
        rst = 1'b0; flush = 1'b0; stall = S_RUN;
        ex_wd = 5'd3; ex_wreg = 1'b1; ex_wdata = 32'h1234_5678;
        #1;
        chk("pt.pre_wdata", 64'(mem_wdata), 64'(expand(8'd13).wdata));
        @(posedge clk); #1;
        chk("pt.wd",    64'(mem_wd),    64'd3);
        chk("pt.wreg",  64'(mem_wreg),  64'd1);
        chk("pt.wdata", 64'(mem_wdata), 64'h1234_5678);

        // Full hold for three cycles while EX inputs churn.
        ex_wdata = 32'hAAAA_5555; ex_wd = 5'd17; ex_wreg = 1'b1;
        @(posedge clk); #1;
        chk("hold.load", 64'(mem_wdata), 64'hAAAA_5555);
        stall = S_HOLD;
        for (int c = 0; c < 3; c++) begin
            ex_wdata = 32'h0BAD_0000 + 32'(c); ex_wd = 5'(c); ex_wreg = 1'b0;
            hilo_i = P2 + 64'(c); cnt_i = 2'd1;
            @(posedge clk); #1;
            chk($sformatf("hold%0d.wdata", c), 64'(mem_wdata), 64'hAAAA_5555);
            chk($sformatf("hold%0d.wd", c),    64'(mem_wd),    64'd17);
            chk($sformatf("hold%0d.wreg", c),  64'(mem_wreg),  64'd1);
            chk($sformatf("hold%0d.hilo", c),  hilo_o,         64'd0);
            chk($sformatf("hold%0d.cnt", c),   64'(cnt_o),     64'd0);
        end
        stall = S_RUN;
        @(posedge clk); #1;
        chk("release.wdata", 64'(mem_wdata), 64'h0BAD_0002);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
